icache_perf_mon: RTL and testbench

//  Synthesisable icache performance monitor; replaces behavioural bench-side stat counters.

---
 rtl/icache_perf_mon.sv | 181 ++++++++++++++++++
 tb/tb_icache_perf_mon.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_perf_mon.sv
// Instruction-cache performance monitor: event counters, per-way hit counts and access
// latency, all read back through a snapshot bank with a one-cycle read handshake.
module icache_perf_mon #(
    parameter int CNT_WIDTH = 32,
    parameter int LAT_WIDTH = 16,
    parameter int NUM_WAYS  = 2,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 proc_valid,
    input  logic                 proc_ready,
    input  logic                 debug_miss,
    input  logic [NUM_WAYS-1:0]  hit_way,
    input  logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    input  logic                 freeze,
    input  logic                 clear,
    input  logic                 snapshot,
    input  logic                 rd_req,
    input  logic [3:0]           rd_addr,
    output logic                 rd_ack,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic                 proto_err
);

    generate
        if (NUM_WAYS < 1 || NUM_WAYS > 10) begin : g_bad_ways
            $error("icache_perf_mon: NUM_WAYS must be in 1..10");
        end
    endgenerate

    localparam int NUM_REGS = 6 + NUM_WAYS;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [LAT_WIDTH-1:0] lat_q, lat_d, last_q, last_d, max_q, max_d;
    logic [CNT_WIDTH-1:0] acc_q, acc_d, miss_cnt_q, miss_cnt_d;
    logic [CNT_WIDTH-1:0] mem_q, mem_d, stall_q, stall_d;
    logic [CNT_WIDTH-1:0] way_q [NUM_WAYS];
    logic [CNT_WIDTH-1:0] way_d [NUM_WAYS];
    logic [CNT_WIDTH-1:0] shadow_q [NUM_REGS];
    logic [CNT_WIDTH-1:0] shadow_d [NUM_REGS];
    logic                 miss_q, miss_d, proto_err_q, proto_err_d, rd_ack_q, rd_ack_d;
    logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d, rd_sel;
    logic                 access, stall, multi_hit;
    logic [LAT_WIDTH-1:0] lat_done;

    function automatic logic [CNT_WIDTH-1:0] cnt_step(input logic [CNT_WIDTH-1:0] v,
                                                      input logic en);
        if (!en) return v;
        if (&v) return SATURATE ? v : '0;
        return v + CNT_WIDTH'(1);
    endfunction

    // Latency always saturates, independent of the counter wrap mode.
    function automatic logic [LAT_WIDTH-1:0] lat_inc(input logic [LAT_WIDTH-1:0] v);
        return (&v) ? v : v + LAT_WIDTH'(1);
    endfunction

    always_comb begin
        access    = proc_valid & proc_ready;
        stall     = proc_valid & ~proc_ready;
        multi_hit = |(hit_way & (hit_way - NUM_WAYS'(1)));
        lat_done  = lat_inc(lat_q);

        state_d     = state_q;
        lat_d       = lat_q;
        last_d      = last_q;
        max_d       = max_q;
        acc_d       = acc_q;
        miss_cnt_d  = miss_cnt_q;
        mem_d       = mem_q;
        stall_d     = stall_q;
        way_d       = way_q;
        shadow_d    = shadow_q;
        proto_err_d = proto_err_q;
        miss_d      = debug_miss;

        if (clear) begin
            state_d    = ST_IDLE;
            lat_d      = '0;
            last_d     = '0;
            max_d      = '0;
            acc_d      = '0;
            miss_cnt_d = '0;
            mem_d      = '0;
            stall_d    = '0;
            for (int w = 0; w < NUM_WAYS; w++) way_d[w] = '0;
        end else if (!freeze) begin
            acc_d      = cnt_step(acc_q, access);
            miss_cnt_d = cnt_step(miss_cnt_q, debug_miss & ~miss_q);
            mem_d      = cnt_step(mem_q, mem_req_valid & mem_req_ready);
            stall_d    = cnt_step(stall_q, stall);
            for (int w = 0; w < NUM_WAYS; w++)
                way_d[w] = cnt_step(way_q[w], access & hit_way[w] & ~multi_hit);
            if (access && multi_hit) proto_err_d = 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        last_d = LAT_WIDTH'(1);
                        if (max_q < LAT_WIDTH'(1)) max_d = LAT_WIDTH'(1);
                    end else if (stall) begin
                        state_d = ST_BUSY;
                        lat_d   = LAT_WIDTH'(1);
                    end
                end
                default: begin
                    if (stall) begin
                        lat_d = lat_done;
                    end else if (access) begin
                        last_d  = lat_done;
                        if (lat_done > max_q) max_d = lat_done;
                        state_d = ST_IDLE;
                    end else begin
                        // Request withdrawn before completion: nothing recorded.
                        proto_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            endcase
        end

        if (snapshot) begin
            shadow_d[0] = acc_q;
            shadow_d[1] = miss_cnt_q;
            shadow_d[2] = mem_q;
            shadow_d[3] = stall_q;
            shadow_d[4] = CNT_WIDTH'(last_q);
            shadow_d[5] = CNT_WIDTH'(max_q);
            for (int w = 0; w < NUM_WAYS; w++) shadow_d[6+w] = way_q[w];
        end

        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_addr == 4'(i)) rd_sel = shadow_q[i];
        rd_ack_d  = rd_req;
        rd_data_d = rd_req ? rd_sel : rd_data_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            last_q      <= '0;
            max_q       <= '0;
            acc_q       <= '0;
            miss_cnt_q  <= '0;
            mem_q       <= '0;
            stall_q     <= '0;
            for (int w = 0; w < NUM_WAYS; w++) way_q[w] <= '0;
            for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
            miss_q      <= 1'b0;
            proto_err_q <= 1'b0;
            rd_ack_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            last_q      <= last_d;
            max_q       <= max_d;
            acc_q       <= acc_d;
            miss_cnt_q  <= miss_cnt_d;
            mem_q       <= mem_d;
            stall_q     <= stall_d;
            way_q       <= way_d;
            shadow_q    <= shadow_d;
            miss_q      <= miss_d;
            proto_err_q <= proto_err_d;
            rd_ack_q    <= rd_ack_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_ack    = rd_ack_q;
    assign rd_data   = rd_data_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_icache_perf_mon.sv
// Self-checking bench for icache_perf_mon: directed scenarios plus a randomized run
// compared against a transaction-level model of the counters.
module tb_icache_perf_mon;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, proc_valid, proc_ready, debug_miss;
    logic        mem_req_valid, mem_req_ready, freeze, clear, snapshot, rd_req;
    logic [1:0]  hit_way;
    logic [3:0]  rd_addr;
    logic        ack_m, ack_s, ack_w, err_m, err_s, err_w;
    logic [31:0] data_m;
    logic [3:0]  data_s, data_w;

    int total = 0;
    int bad   = 0;
    bit rand_mem = 1'b0;
    int mem_hs = 0;

    icache_perf_mon u_dut (
        .clk(clk), .resetn(resetn), .proc_valid(proc_valid), .proc_ready(proc_ready),
        .debug_miss(debug_miss), .hit_way(hit_way), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .freeze(freeze), .clear(clear), .snapshot(snapshot),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(ack_m), .rd_data(data_m), .proto_err(err_m)
    );

    icache_perf_mon #(.CNT_WIDTH(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .resetn(resetn), .proc_valid(proc_valid), .proc_ready(proc_ready),
        .debug_miss(debug_miss), .hit_way(hit_way), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .freeze(freeze), .clear(clear), .snapshot(snapshot),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(ack_s), .rd_data(data_s), .proto_err(err_s)
    );

    icache_perf_mon #(.CNT_WIDTH(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .resetn(resetn), .proc_valid(proc_valid), .proc_ready(proc_ready),
        .debug_miss(debug_miss), .hit_way(hit_way), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .freeze(freeze), .clear(clear), .snapshot(snapshot),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(ack_w), .rd_data(data_w), .proto_err(err_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        if (rand_mem) begin
            mem_req_valid = 1'($urandom);
            mem_req_ready = 1'($urandom);
            if (mem_req_valid && mem_req_ready) mem_hs++;
        end else begin
            mem_req_valid = 1'b0;
            mem_req_ready = 1'b0;
        end
        tick();
    endtask

    task automatic do_reset();
        proc_valid = 0; proc_ready = 0; debug_miss = 0; hit_way = 0;
        mem_req_valid = 0; mem_req_ready = 0; freeze = 0; clear = 0;
        snapshot = 0; rd_req = 0; rd_addr = 0;
        resetn = 0;
        tick(); tick();
        resetn = 1;
        tick();
    endtask

    // waits = number of valid-but-not-ready cycles before the handshake
    task automatic access(input int waits, input logic [1:0] hw);
        for (int i = 0; i < waits; i++) begin
            proc_valid = 1; proc_ready = 0; hit_way = 2'($urandom);
            step();
        end
        proc_valid = 1; proc_ready = 1; hit_way = hw;
        step();
        proc_valid = 0; proc_ready = 0; hit_way = 0;
    endtask

    task automatic snap();
        snapshot = 1;
        tick();
        snapshot = 0;
    endtask

    task automatic rd(input int a);
        rd_req = 1; rd_addr = 4'(a);
        tick();
        rd_req = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ack_m !== 1'b0) begin bad++; $display("FAIL reset_ack got=%0d want=0", ack_m); end
        total++; if (data_m !== 32'd0) begin bad++; $display("FAIL reset_data got=%0d want=0", data_m); end
        total++; if (err_m !== 1'b0) begin bad++; $display("FAIL reset_err got=%0d want=0", err_m); end
        for (int a = 0; a < 10; a++) begin
            rd(a);
            total++;
            if (ack_m !== 1'b1 || data_m !== 32'd0) begin
                bad++; $display("FAIL reset_read addr%0d ack=%0d data=%0d want ack=1 data=0", a, ack_m, data_m);
            end
        end
    endtask

    task automatic test_basic();
        int addrs [6] = '{0, 6, 4, 5, 3, 7};
        int exps  [6] = '{10, 10, 1, 1, 0, 0};
        do_reset();
        repeat (10) access(0, 2'b01);
        snap();
        for (int i = 0; i < 6; i++) begin
            rd(addrs[i]);
            total++;
            if (ack_m !== 1'b1 || data_m !== 32'(exps[i])) begin
                bad++; $display("FAIL basic addr%0d ack=%0d got=%0d want=%0d", addrs[i], ack_m, data_m, exps[i]);
            end
        end
    endtask

    task automatic test_latency();
        int addrs [6] = '{3, 4, 5, 1, 2, 0};
        int exps  [6] = '{4, 5, 5, 1, 4, 1};
        do_reset();
        access(4, 2'b00);
        debug_miss = 1; tick(); tick();
        debug_miss = 0; tick();
        mem_req_valid = 1; mem_req_ready = 0; tick();
        mem_req_ready = 1; repeat (4) tick();
        mem_req_valid = 0; mem_req_ready = 0;
        snap();
        for (int i = 0; i < 6; i++) begin
            rd(addrs[i]);
            total++;
            if (data_m !== 32'(exps[i])) begin
                bad++; $display("FAIL latency addr%0d got=%0d want=%0d", addrs[i], data_m, exps[i]);
            end
        end
        access(1, 2'b00);
        snap();
        rd(4);
        total++; if (data_m !== 32'd2) begin bad++; $display("FAIL latency_last2 got=%0d want=2", data_m); end
        rd(5);
        total++; if (data_m !== 32'd5) begin bad++; $display("FAIL latency_maxkeep got=%0d want=5", data_m); end
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (20) access(0, 2'b01);
        snap();
        rd(0);
        total++; if (data_m !== 32'd20) begin bad++; $display("FAIL sat_wide got=%0d want=20", data_m); end
        total++; if (ack_s !== 1'b1 || data_s !== 4'd15) begin bad++; $display("FAIL sat_narrow got=%0d want=15", data_s); end
        total++; if (ack_w !== 1'b1 || data_w !== 4'd4) begin bad++; $display("FAIL wrap_narrow got=%0d want=4", data_w); end
    endtask

    task automatic test_snap_clear();
        do_reset();
        repeat (7) access(0, 2'b01);
        snapshot = 1; clear = 1;
        tick();
        snapshot = 0; clear = 0;
        repeat (3) access(0, 2'b01);
        rd_req = 1; rd_addr = 0; snapshot = 1;
        tick();
        rd_req = 0; snapshot = 0;
        total++; if (ack_m !== 1'b1 || data_m !== 32'd7) begin bad++; $display("FAIL snapclr_first ack=%0d got=%0d want=7", ack_m, data_m); end
        tick();
        total++; if (ack_m !== 1'b0 || data_m !== 32'd7) begin bad++; $display("FAIL rd_hold ack=%0d got=%0d want ack=0 data=7", ack_m, data_m); end
        rd(0);
        total++; if (data_m !== 32'd3) begin bad++; $display("FAIL snapclr_second got=%0d want=3", data_m); end
        rd_req = 1; rd_addr = 6;
        tick();
        total++; if (ack_m !== 1'b1 || data_m !== 32'd3) begin bad++; $display("FAIL b2b_way0 ack=%0d got=%0d want=3", ack_m, data_m); end
        rd_addr = 4;
        tick();
        rd_req = 0;
        total++; if (ack_m !== 1'b1 || data_m !== 32'd1) begin bad++; $display("FAIL b2b_last ack=%0d got=%0d want=1", ack_m, data_m); end
        rd(12);
        total++; if (data_m !== 32'd0) begin bad++; $display("FAIL unmapped_addr got=%0d want=0", data_m); end
    endtask

    task automatic test_proto();
        int addrs [4] = '{4, 5, 3, 0};
        int exps  [4] = '{3, 3, 4, 1};
        do_reset();
        access(2, 2'b01);
        proc_valid = 1; proc_ready = 0; tick(); tick();
        proc_valid = 0; tick();
        total++; if (err_m !== 1'b1) begin bad++; $display("FAIL abort_err got=%0d want=1", err_m); end
        snap();
        for (int i = 0; i < 4; i++) begin
            rd(addrs[i]);
            total++;
            if (data_m !== 32'(exps[i])) begin
                bad++; $display("FAIL abort addr%0d got=%0d want=%0d", addrs[i], data_m, exps[i]);
            end
        end
        do_reset();
        access(0, 2'b11);
        total++; if (err_m !== 1'b1) begin bad++; $display("FAIL multihit_err got=%0d want=1", err_m); end
        access(0, 2'b10);
        snap();
        rd(0);
        total++; if (data_m !== 32'd2) begin bad++; $display("FAIL multihit_acc got=%0d want=2", data_m); end
        rd(6);
        total++; if (data_m !== 32'd0) begin bad++; $display("FAIL multihit_way0 got=%0d want=0", data_m); end
        rd(7);
        total++; if (data_m !== 32'd1) begin bad++; $display("FAIL multihit_way1 got=%0d want=1", data_m); end
    endtask

    task automatic test_freeze();
        int exps [8] = '{2, 0, 0, 0, 1, 1, 2, 0};
        do_reset();
        repeat (2) access(0, 2'b01);
        freeze = 1; debug_miss = 1; rand_mem = 1;
        repeat (5) access($urandom_range(0, 3), 2'b10);
        rand_mem = 0;
        freeze = 0;
        repeat (3) tick();
        debug_miss = 0; tick();
        snap();
        for (int a = 0; a < 8; a++) begin
            rd(a);
            total++;
            if (data_m !== 32'(exps[a])) begin
                bad++; $display("FAIL freeze addr%0d got=%0d want=%0d", a, data_m, exps[a]);
            end
        end
    endtask

    task automatic test_random();
        int m_acc = 0, m_miss = 0, m_stall = 0, m_last = 0, m_max = 0;
        int m_way [2] = '{0, 0};
        int exps [8];
        do_reset();
        rand_mem = 1; mem_hs = 0;
        repeat (25) begin
            if ($urandom_range(0, 2) == 0) begin
                debug_miss = 1;
                repeat ($urandom_range(1, 3)) step();
                debug_miss = 0;
                step();
                m_miss++;
            end
            begin
                int waits = $urandom_range(0, 5);
                logic [1:0] hw = 2'($urandom_range(0, 2));
                access(waits, hw);
                m_acc++;
                m_stall += waits;
                m_last = waits + 1;
                if (m_last > m_max) m_max = m_last;
                if (hw == 2'b01) m_way[0]++;
                if (hw == 2'b10) m_way[1]++;
            end
            repeat ($urandom_range(0, 2)) step();
        end
        rand_mem = 0; step();
        snap();
        exps = '{m_acc, m_miss, mem_hs, m_stall, m_last, m_max, m_way[0], m_way[1]};
        for (int a = 0; a < 8; a++) begin
            rd(a);
            total++;
            if (data_m !== 32'(exps[a])) begin
                bad++; $display("FAIL random addr%0d got=%0d want=%0d", a, data_m, exps[a]);
            end
        end
        total++; if (err_m !== 1'b0) begin bad++; $display("FAIL random_err got=%0d want=0", err_m); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        access(0, 2'b11);
        repeat (3) access(0, 2'b01);
        snap();
        proc_valid = 1; proc_ready = 0; tick(); tick();
        #2 resetn = 0;
        #1;
        total++; if (err_m !== 1'b0) begin bad++; $display("FAIL async_reset_err got=%0d want=0", err_m); end
        proc_valid = 0;
        tick();
        resetn = 1;
        tick();
        for (int a = 0; a < 8; a++) begin
            rd(a);
            total++;
            if (data_m !== 32'd0) begin
                bad++; $display("FAIL midreset addr%0d got=%0d want=0", a, data_m);
            end
        end
        access(0, 2'b01);
        snap();
        rd(4);
        total++; if (data_m !== 32'd1 || err_m !== 1'b0) begin bad++; $display("FAIL midreset_fsm last=%0d err=%0d want last=1 err=0", data_m, err_m); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 0;
        test_reset();
        test_basic();
        test_latency();
        test_saturate();
        test_snap_clear();
        test_proto();
        test_freeze();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
